trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
Machine-mode trap/return/WFI sequencer for the 5-stage RV32 core. Sits beside the EXE stage and owns mstatus/mie/mtvec/mepc/mcause. Takes external/timer interrupts at instruction boundaries, executes MRET and stalls the core on WFI. Drives the CSR_stall, CSR_control and CSR_ret inputs of the hazard unit, and provides the PC redirect target.

Parameters:
MTVEC_RST, 32'h0001_0000, reset value of mtvec.
XLEN, 32, data/PC width (only 32 supported).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pipe_stall_i  in  1  IM_stall|DM_stall; pipeline frozen this cycle
exe_valid  in  1  EXE holds a real (non-bubble) instruction
exe_next_pc  in  XLEN  PC that would execute after the EXE instruction (branch-resolved)
mret_i  in  1  EXE instruction is MRET
wfi_i  in  1  EXE instruction is WFI
ext_irq  in  1  external interrupt, level
tmr_irq  in  1  timer interrupt, level
csr_we  in  1  CSR write from WB
csr_addr  in  12  CSR address (write and read)
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  combinational read data
csr_stall  out  1  to hazard unit CSR_stall
csr_control  out  1  to hazard unit CSR_control (trap redirect)
csr_ret  out  1  to hazard unit CSR_ret (MRET redirect)
redirect_pc  out  XLEN  target PC, valid while csr_control|csr_ret

Behaviour:
- Reset: state IDLE; all outputs 0; mstatus.MIE/MPIE=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0. Reset in any state, including WFI_WAIT/TRAP/RET, returns to IDLE the next cycle with csr_stall low.
- CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, others read 0); mie 0x304 (MEIE bit11, MTIE bit7); mtvec 0x305 (bits[1:0] forced 0, direct mode); mepc 0x341 (bits[1:0] forced 0); mcause 0x342 (read-only here); mip 0x344 (MEIP=ext_irq, MTIP=tmr_irq, read-only). Unlisted addresses read 0 and ignore writes.
- A CSR write takes effect on the clock edge when csr_we & ~pipe_stall_i. A hardware trap/MRET update of the same register in the same cycle wins over the write.
- pend = (ext_irq&MEIE) | (tmr_irq&MTIE). take = pend & MIE.
- Accept condition: state==IDLE & exe_valid & ~pipe_stall_i. Priority when accepting: interrupt > MRET > WFI.
- IDLE, take: mepc<=exe_next_pc; mcause<=32'h8000_000B if ext_irq&MEIE, else 32'h8000_0007; MPIE<=MIE; MIE<=0 -> TRAP.
- IDLE, mret_i: MIE<=MPIE; MPIE<=1 -> RET.
- IDLE, wfi_i & ~pend: capture exe_next_pc into wfi_pc -> WFI_WAIT. With wfi_i & pend, the WFI acts as a NOP.
- TRAP: csr_control=1, redirect_pc=mtvec. Stay in TRAP while pipe_stall_i=1. Exit to IDLE after the first cycle with pipe_stall_i=0, so exactly one unstalled flush cycle occurs.
- RET: same handshake as TRAP, with csr_ret=1 and redirect_pc=mepc.
- WFI_WAIT: csr_stall=1. pend is sampled independently of MIE.
  - pend & MIE: mepc<=wfi_pc, mcause and MIE/MPIE updated as in the trap case -> TRAP.
  - pend & ~MIE: -> IDLE; csr_stall drops the next cycle and execution resumes after the WFI.
- csr_stall, csr_control and csr_ret are decoded from the registered state. They are mutually exclusive and have 1-cycle latency from acceptance.
- Interrupts arriving while not in IDLE/WFI_WAIT are held off; the level inputs are re-evaluated on return to IDLE.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> all outputs 0, csr_rdata @0x305 = 32'h0001_0000, @0x300 = 0.
- Timer IRQ: write mie=0x80, mstatus=0x8; tmr_irq=1, exe_valid=1, exe_next_pc=0x200 -> next cycle csr_control=1 for exactly 1 cycle, redirect_pc=mtvec; mepc=0x200, mcause=0x80000007, mstatus=0x80.
- Trap held under stall: same as previous, but pipe_stall_i=1 for 3 cycles after acceptance -> csr_control stays high for 4 cycles and drops after the first unstalled cycle; mepc written once.
- MRET: after trap, mret_i=1 -> csr_ret=1 one cycle, redirect_pc=0x200, mstatus=0x88.
- WFI then wake with ext_irq, MIE=1, MEIE=1: wfi_i with exe_next_pc=0x404 -> csr_stall=1 for 5 idle cycles; ext_irq=1 -> csr_control=1, mepc=0x404, mcause=0x8000000B. Repeat with MIE=0 -> csr_stall drops, no trap.
- Simultaneous events: ext_irq, tmr_irq and mret_i all high with MIE=1 -> trap taken, mcause=0x8000000B, MRET ignored. CSR write to mepc in the same cycle -> mepc = trap value.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// CSR access bus between the writeback/decode side of the core and the trap sequencer.
// The master drives the write/address side and samples the combinational read data.
interface trap_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    modport master (output csr_we, output csr_addr, output csr_wdata, input csr_rdata);
    modport slave  (input csr_we, input csr_addr, input csr_wdata, output csr_rdata);
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap / MRET / WFI sequencer for the 5-stage RV32 core.
// Owns mstatus, mie, mtvec, mepc and mcause; drives the hazard-unit stall/redirect controls.
module trap_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0001_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_stall_i,
    input  logic                   exe_valid,
    input  logic [XLEN-1:0]        exe_next_pc,
    input  logic                   mret_i,
    input  logic                   wfi_i,
    input  logic                   ext_irq,
    input  logic                   tmr_irq,
    trap_sequencer_if.slave        csr_bus,
    output logic                   csr_stall,
    output logic                   csr_control,
    output logic                   csr_ret,
    output logic [XLEN-1:0]        redirect_pc
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    typedef enum logic [1:0] {IDLE, TRAP, RET, WFI_WAIT} state_e;

    state_e          state_q, state_d;
    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic            meie_q, meie_d, mtie_q, mtie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] wfi_pc_q, wfi_pc_d;

    logic            pend, do_trap;
    logic [XLEN-1:0] trap_pc, trap_cause;
    logic            unused_lsbs;

    assign unused_lsbs = ^{csr_bus.csr_wdata[1:0], exe_next_pc[1:0], wfi_pc_q[1:0]};

    assign pend       = (ext_irq & meie_q) | (tmr_irq & mtie_q);
    assign trap_cause = (ext_irq & meie_q) ? {1'b1, {(XLEN-5){1'b0}}, 4'hB}
                                           : {1'b1, {(XLEN-5){1'b0}}, 4'h7};

    always_comb begin
        state_d  = state_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        meie_d   = meie_q;
        mtie_d   = mtie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        wfi_pc_d = wfi_pc_q;
        do_trap  = 1'b0;
        trap_pc  = exe_next_pc;

        // Software writes first; hardware trap/MRET updates below override them.
        if (csr_bus.csr_we && !pipe_stall_i) begin
            case (csr_bus.csr_addr)
                A_MSTATUS: begin
                    mie_d  = csr_bus.csr_wdata[3];
                    mpie_d = csr_bus.csr_wdata[7];
                end
                A_MIE: begin
                    meie_d = csr_bus.csr_wdata[11];
                    mtie_d = csr_bus.csr_wdata[7];
                end
                A_MTVEC: mtvec_d = {csr_bus.csr_wdata[XLEN-1:2], 2'b00};
                A_MEPC:  mepc_d  = {csr_bus.csr_wdata[XLEN-1:2], 2'b00};
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (exe_valid && !pipe_stall_i) begin
                    if (pend && mie_q) begin
                        do_trap = 1'b1;
                    end else if (mret_i) begin
                        mie_d   = mpie_q;
                        mpie_d  = 1'b1;
                        state_d = RET;
                    end else if (wfi_i && !pend) begin
                        wfi_pc_d = exe_next_pc;
                        state_d  = WFI_WAIT;
                    end
                end
            end
            TRAP, RET: begin
                if (!pipe_stall_i) state_d = IDLE;
            end
            WFI_WAIT: begin
                // Wake on any enabled pending source; only trap if globally enabled.
                if (pend) begin
                    if (mie_q) begin
                        do_trap = 1'b1;
                        trap_pc = wfi_pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_trap) begin
            mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            state_d  = TRAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RST;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            meie_q   <= meie_d;
            mtie_q   <= mtie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
        wfi_pc_q <= wfi_pc_d;
    end

    assign csr_stall   = (state_q == WFI_WAIT);
    assign csr_control = (state_q == TRAP);
    assign csr_ret     = (state_q == RET);

    always_comb begin
        redirect_pc = '0;
        if (state_q == TRAP)     redirect_pc = mtvec_q;
        else if (state_q == RET) redirect_pc = mepc_q;
    end

    always_comb begin
        csr_bus.csr_rdata = '0;
        case (csr_bus.csr_addr)
            A_MSTATUS: csr_bus.csr_rdata = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mie_q, 3'b000};
            A_MIE:     csr_bus.csr_rdata = {{(XLEN-12){1'b0}}, meie_q, 3'b000, mtie_q, 7'b0};
            A_MTVEC:   csr_bus.csr_rdata = mtvec_q;
            A_MEPC:    csr_bus.csr_rdata = mepc_q;
            A_MCAUSE:  csr_bus.csr_rdata = mcause_q;
            A_MIP:     csr_bus.csr_rdata = {{(XLEN-12){1'b0}}, ext_irq, 3'b000, tmr_irq, 7'b0};
            default:   csr_bus.csr_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed and randomized bench for trap_sequencer against an architectural CSR/trap model.
module tb_trap_sequencer;
    logic        clk = 1'b0;
    logic        rst, pipe_stall_i, exe_valid, mret_i, wfi_i, ext_irq, tmr_irq;
    logic [31:0] exe_next_pc, redirect_pc;
    logic        csr_stall, csr_control, csr_ret;

    int vectors = 0;
    int miscompares = 0;

    // Architectural model of the machine-mode CSR state.
    logic        m_mie, m_mpie, m_meie, m_mtie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;

    trap_sequencer_if csr_bus ();

    trap_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_stall_i(pipe_stall_i),
        .exe_valid   (exe_valid),
        .exe_next_pc (exe_next_pc),
        .mret_i      (mret_i),
        .wfi_i       (wfi_i),
        .ext_irq     (ext_irq),
        .tmr_irq     (tmr_irq),
        .csr_bus     (csr_bus.slave),
        .csr_stall   (csr_stall),
        .csr_control (csr_control),
        .csr_ret     (csr_ret),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic s, input logic c, input logic r,
                            input logic [31:0] pc);
        chk({tag, "/ctl"}, {29'b0, csr_stall, csr_control, csr_ret}, {29'b0, s, c, r});
        chk({tag, "/pc"}, redirect_pc, pc);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_bus.csr_addr = addr;
        #1;
        chk(tag, csr_bus.csr_rdata, exp);
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
        m_mtvec = 32'h0001_0000; m_mepc = 0; m_mcause = 0;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h304: begin m_meie = d[11]; m_mtie = d[7]; end
            12'h305: m_mtvec = d & 32'hFFFF_FFFC;
            12'h341: m_mepc  = d & 32'hFFFF_FFFC;
            default: ;
        endcase
    endtask

    task automatic model_trap(input logic [31:0] pc, input logic is_ext);
        m_mepc   = pc & 32'hFFFF_FFFC;
        m_mcause = is_ext ? 32'h8000_000B : 32'h8000_0007;
        m_mpie   = m_mie;
        m_mie    = 1'b0;
    endtask

    function automatic logic [31:0] m_mstatus();
        return {24'b0, m_mpie, 3'b000, m_mie, 3'b000};
    endfunction

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_bus.csr_we = 1'b1; csr_bus.csr_addr = a; csr_bus.csr_wdata = d;
        tick();
        csr_bus.csr_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic chk_csrs(input string tag);
        rd_chk({tag, "/mstatus"}, 12'h300, m_mstatus());
        rd_chk({tag, "/mie"}, 12'h304, {20'b0, m_meie, 3'b000, m_mtie, 7'b0});
        rd_chk({tag, "/mtvec"}, 12'h305, m_mtvec);
        rd_chk({tag, "/mepc"}, 12'h341, m_mepc);
        rd_chk({tag, "/mcause"}, 12'h342, m_mcause);
    endtask

    initial begin
        logic [11:0] addr_tab [7];
        logic [31:0] pc;
        logic        r_ext, r_tmr, r_mret, r_wfi, pend;

        addr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
        rst = 1; pipe_stall_i = 0; exe_valid = 0; exe_next_pc = 0; mret_i = 0; wfi_i = 0;
        ext_irq = 0; tmr_irq = 0;
        csr_bus.csr_we = 0; csr_bus.csr_addr = 0; csr_bus.csr_wdata = 0;
        model_reset();

        tick(); tick();
        chk_outs("rst_hold", 0, 0, 0, 0);
        rst = 0;
        tick();
        chk_outs("rst_rel", 0, 0, 0, 0);
        rd_chk("rst/mtvec", 12'h305, 32'h0001_0000);
        rd_chk("rst/mstatus", 12'h300, 32'h0);

        // mtvec low bits are forced; writes while stalled are dropped.
        wr(12'h305, 32'h0002_0003);
        pipe_stall_i = 1; csr_bus.csr_we = 1; csr_bus.csr_addr = 12'h305; csr_bus.csr_wdata = 32'h0005_0000;
        tick();
        csr_bus.csr_we = 0; pipe_stall_i = 0;
        rd_chk("mtvec_stallwr", 12'h305, 32'h0002_0000);
        wr(12'h7C0, 32'hFFFF_FFFF);
        rd_chk("unlisted", 12'h7C0, 32'h0);

        // Timer interrupt.
        wr(12'h304, 32'h80); wr(12'h300, 32'h8);
        tmr_irq = 1; exe_valid = 1; exe_next_pc = 32'h200;
        tick();
        exe_valid = 0; tmr_irq = 0;
        chk_outs("tmr_trap", 0, 1, 0, m_mtvec);
        model_trap(32'h200, 0);
        tick();
        chk_outs("tmr_done", 0, 0, 0, 0);
        chk_csrs("tmr");
        chk("tmr/mstatus80", m_mstatus(), 32'h80);

        // Trap held under three stall cycles.
        wr(12'h300, 32'h8);
        tmr_irq = 1; exe_valid = 1; exe_next_pc = 32'h300;
        tick();
        chk_outs("stl_c1", 0, 1, 0, m_mtvec);
        model_trap(32'h300, 0);
        pipe_stall_i = 1; exe_next_pc = 32'h7F0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs("stl_hold", 0, 1, 0, m_mtvec);
        end
        pipe_stall_i = 0; exe_valid = 0; tmr_irq = 0;
        tick();
        chk_outs("stl_exit", 0, 0, 0, 0);
        chk_csrs("stl");

        // MRET.
        mret_i = 1; exe_valid = 1;
        tick();
        mret_i = 0; exe_valid = 0;
        chk_outs("mret", 0, 0, 1, 32'h300);
        m_mie = m_mpie; m_mpie = 1;
        tick();
        chk_outs("mret_done", 0, 0, 0, 0);
        rd_chk("mret/mstatus", 12'h300, 32'h88);

        // WFI woken by external interrupt with MIE=1.
        wr(12'h304, 32'h800);
        wfi_i = 1; exe_valid = 1; exe_next_pc = 32'h404;
        tick();
        wfi_i = 0; exe_valid = 0;
        chk_outs("wfi_enter", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_outs("wfi_wait", 1, 0, 0, 0);
        end
        ext_irq = 1;
        tick();
        ext_irq = 0;
        chk_outs("wfi_wake", 0, 1, 0, m_mtvec);
        model_trap(32'h404, 1);
        tick();
        chk_outs("wfi_trapdone", 0, 0, 0, 0);
        chk_csrs("wfi");

        // WFI with MIE=0: wake without trap.
        wfi_i = 1; exe_valid = 1; exe_next_pc = 32'h508;
        tick();
        wfi_i = 0; exe_valid = 0;
        chk_outs("wfi0_enter", 1, 0, 0, 0);
        ext_irq = 1;
        tick();
        chk_outs("wfi0_wake", 0, 0, 0, 0);
        tick();
        ext_irq = 0;
        chk_outs("wfi0_idle", 0, 0, 0, 0);
        chk_csrs("wfi0");

        // Simultaneous ext, tmr, MRET and mepc write.
        wr(12'h300, 32'h8); wr(12'h304, 32'h880);
        ext_irq = 1; tmr_irq = 1; mret_i = 1; exe_valid = 1; exe_next_pc = 32'h600;
        csr_bus.csr_we = 1; csr_bus.csr_addr = 12'h341; csr_bus.csr_wdata = 32'hABC;
        tick();
        csr_bus.csr_we = 0; ext_irq = 0; tmr_irq = 0; mret_i = 0; exe_valid = 0;
        chk_outs("simul", 0, 1, 0, m_mtvec);
        model_trap(32'h600, 1);
        tick();
        chk_outs("simul_done", 0, 0, 0, 0);
        chk_csrs("simul");

        // Reset while waiting in WFI.
        wfi_i = 1; exe_valid = 1; exe_next_pc = 32'h700;
        tick();
        wfi_i = 0; exe_valid = 0;
        chk_outs("wfi_rst_enter", 1, 0, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        chk_outs("wfi_rst", 0, 0, 0, 0);
        chk_csrs("wfi_rst");

        // Randomized events against the model.
        for (int it = 0; it < 40; it++) begin
            wr(12'h300, {24'b0, 1'($urandom_range(0, 1)), 3'b000, 1'($urandom_range(0, 1)), 3'b000});
            wr(12'h304, {20'b0, 1'($urandom_range(0, 1)), 3'b000, 1'($urandom_range(0, 1)), 7'b0});
            wr(addr_tab[$urandom_range(0, 6)], $urandom);
            r_ext = 1'($urandom_range(0, 1)); r_tmr = 1'($urandom_range(0, 1));
            r_mret = 1'($urandom_range(0, 1)); r_wfi = 1'($urandom_range(0, 1));
            pc = $urandom & 32'hFFFF_FFFC;
            ext_irq = r_ext; tmr_irq = r_tmr; mret_i = r_mret; wfi_i = r_wfi;
            exe_valid = 1; exe_next_pc = pc;
            rd_chk("rnd/mip", 12'h344, {20'b0, r_ext, 3'b000, r_tmr, 7'b0});
            pend = (r_ext & m_meie) | (r_tmr & m_mtie);
            tick();
            ext_irq = 0; tmr_irq = 0; mret_i = 0; wfi_i = 0; exe_valid = 0;
            if (pend && m_mie) begin
                chk_outs("rnd_trap", 0, 1, 0, m_mtvec);
                model_trap(pc, r_ext & m_meie);
                tick();
            end else if (r_mret) begin
                chk_outs("rnd_mret", 0, 0, 1, m_mepc);
                m_mie = m_mpie; m_mpie = 1;
                tick();
            end else if (r_wfi && !pend) begin
                chk_outs("rnd_wfi", 1, 0, 0, 0);
                wr(12'h304, 32'h800);
                chk_outs("rnd_wfi_hold", 1, 0, 0, 0);
                ext_irq = 1;
                tick();
                ext_irq = 0;
                if (m_mie) begin
                    chk_outs("rnd_wfi_trap", 0, 1, 0, m_mtvec);
                    model_trap(pc, 1);
                    tick();
                end
            end
            chk_outs("rnd_idle", 0, 0, 0, 0);
            chk_csrs("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
